// File: rtl/bridge_frame_executor.sv
// Purpose : buffers UART-received command frames and executes them one at a time
//           as bus writes/reads; read data is returned to the UART transmitter.
// Latency : frame pulsed in cycle N (empty FIFO, FSM idle) -> req_valid in N+2.
// Backpr. : req_* held until req_accept; SEND holds while tx_busy; a frame that
//           arrives to a full FIFO with no same-cycle pop is dropped (sticky overflow).
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   rx_frame / rx_ready       frame {mode, wdata, addr} and its one-cycle strobe
//   tx_data / tx_en / tx_busy read data, one-cycle TX start, TX busy
//   req_valid/mode/addr/wdata bus request (held stable while req_valid)
//   req_accept                bus master accepts the request
//   rsp_valid / rsp_rdata     read response
//   overflow                  sticky frame-dropped flag
//   fifo_level                occupied frame buffer entries
//
// Optional feature: define BRIDGE_READ_TIMEOUT_EN to bound the wait for a read
// response to TIMEOUT_CYCLES cycles; on expiry all-ones is returned as read data.

module bridge_frame_executor #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [DATA_WIDTH+ADDR_WIDTH:0]   rx_frame,
    input  logic                             rx_ready,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_en,
    input  logic                             tx_busy,
    output logic                             req_valid,
    output logic                             req_mode,
    output logic [ADDR_WIDTH-1:0]            req_addr,
    output logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic                             req_accept,
    input  logic                             rsp_valid,
    input  logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

    localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    // Elaboration-time parameter sanity checks.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_SEND     = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    logic [FW-1:0]          mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic                   fifo_empty, fifo_full;
    logic                   push, pop, drop;
    logic [FW-1:0]          head;
    logic                   head_mode;
    logic [DATA_WIDTH-1:0]  head_wdata;
    logic [ADDR_WIDTH-1:0]  head_addr;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));

    // The FSM consumes the head only from IDLE, so a pop frees a slot in the
    // same cycle and lets a push into a full buffer through.
    assign pop  = (state_q == S_IDLE) && !fifo_empty;
    assign push = rx_ready && (!fifo_full || pop);
    assign drop = rx_ready && fifo_full && !pop;

    assign head       = mem_q[rd_ptr_q];
    assign head_mode  = head[FW-1];
    assign head_wdata = head[FW-2:ADDR_WIDTH];
    assign head_addr  = head[ADDR_WIDTH-1:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q || drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset: emptiness is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_q[wr_ptr_q] <= rx_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Read-response timeout
    // ------------------------------------------------------------------
    logic tmo_hit;

`ifdef BRIDGE_READ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Fires on the TIMEOUT_CYCLES-th consecutive WAIT_RSP cycle without a response.
    assign tmo_hit = (state_q == S_WAIT_RSP) && !rsp_valid &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_WAIT_RSP && state_d == S_WAIT_RSP) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Executor FSM
    // ------------------------------------------------------------------
    logic                   req_valid_q, req_valid_d;
    logic                   req_mode_q,  req_mode_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q,  req_addr_d;
    logic [DATA_WIDTH-1:0]  req_wdata_q, req_wdata_d;
    logic [DATA_WIDTH-1:0]  tx_data_q,   tx_data_d;
    logic                   tx_en_q,     tx_en_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_accept) begin
                    state_d = req_mode_q ? S_IDLE : S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_valid || tmo_hit) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so that req_valid
    // is high exactly in ISSUE and tx_en in the cycle after SEND sees !tx_busy.
    always_comb begin
        req_valid_d = (state_d == S_ISSUE);
        req_mode_d  = req_mode_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = (state_q == S_SEND) && !tx_busy;
        if (pop) begin
            req_mode_d  = head_mode;
            req_addr_d  = head_addr;
            req_wdata_d = head_mode ? head_wdata : '0;
        end
        if (state_q == S_WAIT_RSP) begin
            if (rsp_valid) begin
                tx_data_d = rsp_rdata;
            end else if (tmo_hit) begin
                tx_data_d = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_valid_q <= 1'b0;
            req_mode_q  <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_mode_q  <= req_mode_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_mode   = req_mode_q;
    assign req_addr   = req_addr_q;
    assign req_wdata  = req_wdata_q;
    assign tx_data    = tx_data_q;
    assign tx_en      = tx_en_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_bridge_frame_executor.sv
// Purpose : directed, table-driven bench for bridge_frame_executor.
// Latency : checks the N+2 request latency and one-cycle tx_en timing.
// Backpr. : exercises req_accept stalls, tx_busy holds and FIFO overflow.

module tb_bridge_frame_executor;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int FD = 4;
    localparam int TC = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [DW+AW:0]  rx_frame;
    logic            rx_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_en;
    logic            tx_busy;
    logic            req_valid;
    logic            req_mode;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic            req_accept;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            overflow;
    logic [2:0]      fifo_level;

    always #5 clk = ~clk;

    bridge_frame_executor #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_frame   (rx_frame),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .tx_busy    (tx_busy),
        .req_valid  (req_valid),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_accept (req_accept),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    int checks = 0;
    int errors = 0;

    // Event counters and accepted-request log, sampled on the falling edge.
    int            tx_en_cnt = 0;
    int            req_cnt   = 0;
    logic [AW-1:0] acc_addr[$];
    logic [DW-1:0] acc_wdata[$];

    always @(negedge clk) begin
        if (tx_en === 1'b1) tx_en_cnt++;
        if (req_valid === 1'b1) begin
            req_cnt++;
            if (req_accept === 1'b1) begin
                acc_addr.push_back(req_addr);
                acc_wdata.push_back(req_wdata);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        rx_ready  = 1'b0;
        rsp_valid = 1'b0;
        tx_busy   = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Pulse a frame for one cycle, then wait (bounded) for req_valid.
    // Returns the number of cycles from the pulse cycle to req_valid.
    task automatic send_frame(input logic [DW+AW:0] f, output int lat);
        rx_frame = f;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        lat = 1;
        while (req_valid !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
    endtask

    typedef struct {
        logic          mode;
        logic [DW-1:0] wdata;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_wdata;
        logic [DW-1:0] exp_tx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int            lat, w, t0, r0, base, k;
        logic          stable;
        logic [DW-1:0] last_tx;

        vecs[0] = '{1'b1, 8'hA5, 16'h1234, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 16'h0040, 8'h3C, 8'h00, 8'h3C};
        vecs[2] = '{1'b0, 8'h77, 16'hFFFF, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 8'h11, 16'h8001, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{1'b1, 8'h5A, 16'hBEEF, 8'h00, 8'h5A, 8'h00};

        rstn       = 1'b0;
        rx_frame   = '0;
        rx_ready   = 1'b0;
        tx_busy    = 1'b0;
        req_accept = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_req_valid",  req_valid,  0);
        chk("rst_req_mode",   req_mode,   0);
        chk("rst_req_addr",   req_addr,   0);
        chk("rst_req_wdata",  req_wdata,  0);
        chk("rst_tx_en",      tx_en,      0);
        chk("rst_tx_data",    tx_data,    0);
        chk("rst_overflow",   overflow,   0);
        chk("rst_fifo_level", fifo_level, 0);

        // ---------------- table-driven transactions ----------------
        req_accept = 1'b1;
        last_tx    = 8'h00;
        for (int i = 0; i < 6; i++) begin
            t0 = tx_en_cnt;
            r0 = req_cnt;
            send_frame({vecs[i].mode, vecs[i].wdata, vecs[i].addr}, lat);
            chk($sformatf("v%0d_latency", i), lat, 2);
            chk($sformatf("v%0d_mode", i),  req_mode,  {31'd0, vecs[i].mode});
            chk($sformatf("v%0d_addr", i),  req_addr,  {16'd0, vecs[i].addr});
            chk($sformatf("v%0d_wdata", i), req_wdata, {24'd0, vecs[i].exp_wdata});
            step();
            chk($sformatf("v%0d_valid_drop", i), req_valid, 0);
            if (vecs[i].mode == 1'b0) begin
                repeat (4) step();
                rsp_rdata = vecs[i].rdata;
                rsp_valid = 1'b1;
                step();
                rsp_valid = 1'b0;
                w = 0;
                while (tx_en !== 1'b1 && w < 10) begin
                    step();
                    w++;
                end
                chk($sformatf("v%0d_tx_en_wait", i), w, 1);
                chk($sformatf("v%0d_tx_data", i), tx_data, {24'd0, vecs[i].exp_tx});
                last_tx = vecs[i].exp_tx;
            end else begin
                // A response outside WAIT_RSP must leave tx_data alone.
                rsp_rdata = 8'hEE;
                rsp_valid = 1'b1;
                step();
                rsp_valid = 1'b0;
                repeat (3) step();
                chk($sformatf("v%0d_stray_rsp", i), tx_data, {24'd0, last_tx});
            end
            repeat (2) step();
            chk($sformatf("v%0d_tx_en_count", i), tx_en_cnt - t0, vecs[i].mode ? 0 : 1);
            chk($sformatf("v%0d_req_count", i), req_cnt - r0, 1);
        end

        // ---------------- backpressure in SEND ----------------
        t0 = tx_en_cnt;
        send_frame({1'b0, 8'h00, 16'h0100}, lat);
        chk("bp_latency", lat, 2);
        step();
        tx_busy   = 1'b1;
        rsp_rdata = 8'hC3;
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (tx_en !== 1'b0 || tx_data !== 8'hC3) stable = 1'b0;
            step();
        end
        chk("bp_hold_stable", stable, 1);
        tx_busy = 1'b0;
        chk("bp_no_early_tx_en", tx_en, 0);
        step();
        chk("bp_tx_en_after_fall", tx_en, 1);
        chk("bp_tx_data", tx_data, 8'hC3);
        step();
        chk("bp_tx_en_one_cycle", tx_en, 0);
        chk("bp_tx_en_count", tx_en_cnt - t0, 1);

        // ---------------- overflow: 6 frames, 6th dropped ----------------
        do_reset();
        req_accept = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_frame = {1'b1, 8'(8'h10 + i), 16'(i + 1)};
            rx_ready = 1'b1;
            step();
        end
        rx_ready = 1'b0;
        chk("ovf_level_full", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head_issue", req_addr, 16'h0001);
        base = acc_addr.size();
        req_accept = 1'b1;
        repeat (14) step();
        chk("ovf_exec_count", acc_addr.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            k = base + i;
            if (k < acc_addr.size()) begin
                chk($sformatf("ovf_order_addr%0d", i), acc_addr[k], i + 1);
                chk($sformatf("ovf_order_wdata%0d", i), acc_wdata[k], 8'h10 + i);
            end
        end
        chk("ovf_sticky", overflow, 1);
        chk("ovf_level_drained", fifo_level, 0);

        // ---------------- push into full FIFO with same-cycle pop ----------------
        do_reset();
        chk("ovf_cleared_by_reset", overflow, 0);
        req_accept = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_frame = {1'b1, 8'h00, 16'(16'h0021 + i)};
            rx_ready = 1'b1;
            step();
        end
        rx_ready = 1'b0;
        chk("pp_level_full", fifo_level, 4);
        chk("pp_no_overflow_yet", overflow, 0);
        req_accept = 1'b1;
        step();
        req_accept = 1'b0;
        chk("pp_idle_full_level", fifo_level, 4);
        rx_frame = {1'b1, 8'h00, 16'h0026};
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        chk("pp_push_accepted_no_ovf", overflow, 0);
        chk("pp_level_after", fifo_level, 4);
        chk("pp_next_head", req_addr, 16'h0022);
        base = acc_addr.size();
        req_accept = 1'b1;
        repeat (12) step();
        chk("pp_exec_count", acc_addr.size() - base, 5);
        if (acc_addr.size() - base == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("pp_order%0d", i), acc_addr[base + i], 16'h0022 + i);
            end
        end

        // ---------------- reset during WAIT_RSP ----------------
        do_reset();
        req_accept = 1'b1;
        t0 = tx_en_cnt;
        send_frame({1'b0, 8'h00, 16'h0055}, lat);
        step();
        step();
        rstn     = 1'b0;
        rx_frame = {1'b1, 8'h99, 16'h0777};
        rx_ready = 1'b1;
        step();
        rstn      = 1'b1;
        rx_ready  = 1'b0;
        r0        = req_cnt;
        rsp_rdata = 8'h99;
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        repeat (5) step();
        chk("mr_no_tx_en", tx_en_cnt - t0, 0);
        chk("mr_no_req", req_cnt - r0, 0);
        chk("mr_tx_data", tx_data, 0);
        chk("mr_level", fifo_level, 0);
        chk("mr_req_mode", req_mode, 0);
        chk("mr_req_addr", req_addr, 0);
        chk("mr_req_wdata", req_wdata, 0);
        chk("mr_overflow", overflow, 0);

`ifdef BRIDGE_READ_TIMEOUT_EN
        // ---------------- read timeout ----------------
        t0 = tx_en_cnt;
        send_frame({1'b0, 8'h00, 16'h0042}, lat);
        step();
        // First WAIT_RSP cycle; 16 cycles of waiting, one in SEND, then tx_en.
        k = 0;
        while (tx_en !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("tmo_cycles", k, TC + 1);
        chk("tmo_tx_data", tx_data, 8'hFF);
        step();
        chk("tmo_tx_en_count", tx_en_cnt - t0, 1);
`else
        // ---------------- no timeout: waits for the response ----------------
        t0 = tx_en_cnt;
        send_frame({1'b0, 8'h00, 16'h0042}, lat);
        step();
        repeat (60) step();
        chk("nt_still_waiting", tx_en_cnt - t0, 0);
        rsp_rdata = 8'h5C;
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        repeat (3) step();
        chk("nt_tx_data", tx_data, 8'h5C);
        chk("nt_tx_en_count", tx_en_cnt - t0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bridge_frame_executor.md
BRIDGE_FRAME_EXECUTOR -- requirements
Module: bridge_frame_executor

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, bus data width; ADDR_WIDTH, default 16, bus address width; FIFO_DEPTH, default 4, frame buffer entries (power of 2, >=2); TIMEOUT_CYCLES, default 1024, read-response limit.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- rx_frame  in  DATA_WIDTH+ADDR_WIDTH+1  UART-received frame: MSB = mode (1 write, 0 read), then wdata, then addr in the LSBs.
- rx_ready  in  1  one-cycle pulse; rx_frame is valid this cycle.
- tx_data  out  DATA_WIDTH  read data returned to the UART TX.
- tx_en  out  1  one-cycle UART TX start.
- tx_busy  in  1  UART TX busy.
- req_valid  out  1  bus request pending.
- req_mode  out  1  1 write, 0 read.
- req_addr  out  ADDR_WIDTH  request address.
- req_wdata  out  DATA_WIDTH  write data (0 for reads).
- req_accept  in  1  master port accepts the request.
- rsp_valid  in  1  read data valid.
- rsp_rdata  in  DATA_WIDTH  read data.
- overflow  out  1  sticky: a frame was dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Function
REQ-003 SHALL push rx_frame into a FIFO_DEPTH-entry FIFO on each rx_ready pulse.
REQ-004 SHALL drop the frame and set overflow when rx_ready arrives while the FIFO is full and no pop occurs in the same cycle. If a pop occurs in the same cycle, the push SHALL be accepted.
REQ-005 SHALL implement the FSM states IDLE, ISSUE, WAIT_RSP and SEND.
REQ-006 IDLE: when the FIFO is non-empty, SHALL pop the head, register mode/addr/wdata into req_* and go to ISSUE.
REQ-007 ISSUE: req_valid=1, with req_* held stable. On req_accept, SHALL go to IDLE for a write or WAIT_RSP for a read.
REQ-008 WAIT_RSP: on rsp_valid, SHALL capture rsp_rdata into tx_data and go to SEND. rsp_valid in any other state SHALL be ignored.
REQ-009 SEND: while tx_busy=1, SHALL hold. When tx_busy=0, SHALL assert tx_en for exactly one cycle and return to IDLE.
REQ-010 Latency: a frame pulsed in cycle N into an empty FIFO with the FSM in IDLE SHALL produce req_valid=1 in cycle N+2.
REQ-011 req_accept in the first ISSUE cycle SHALL be honoured, giving at most one transaction per frame.
REQ-012 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 fifo_level SHALL equal pushes minus pops, saturating in the range 0..FIFO_DEPTH.
REQ-014 Frames SHALL execute strictly in arrival order, with no concurrent transactions.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 When rstn=0 at a clk edge: FSM->IDLE; FIFO emptied; fifo_level=0; overflow=0; req_valid=0; req_mode=0; req_addr=0; req_wdata=0; tx_en=0; tx_data=0.
REQ-017 Reset mid-transaction SHALL abandon the transaction with no tx_en and no further req_valid. A frame pulsed while rstn=0 SHALL be discarded.
REQ-018 overflow SHALL be cleared only by reset.

Configuration
REQ-019 With macro BRIDGE_READ_TIMEOUT_EN defined: a counter SHALL run in WAIT_RSP. After TIMEOUT_CYCLES cycles without rsp_valid, the block SHALL load tx_data with all-ones and go to SEND. The counter SHALL clear on leaving WAIT_RSP.
REQ-020 Without BRIDGE_READ_TIMEOUT_EN: WAIT_RSP SHALL wait indefinitely, and no counter logic SHALL be present.

Verification
REQ-021 Write: rx_frame={1,0xA5,0x1234} pulsed with req_accept tied 1 -> one req_valid cycle with mode=1, addr=0x1234, wdata=0xA5; req_valid first high at N+2; no tx_en.
REQ-022 Read: frame {0,0x00,0x0040}; accept; rsp_rdata=0x3C after 5 cycles; tx_busy=0 -> tx_data=0x3C with a single tx_en pulse.
REQ-023 Backpressure: tx_busy held 1 for 20 cycles in SEND -> tx_en occurs only in the cycle after tx_busy falls, and tx_data stays stable throughout.
REQ-024 Overflow: req_accept=0; 6 frames pushed with FIFO_DEPTH=4 -> the FIFO fills (fifo_level reaches 4 once the head has been popped into ISSUE), overflow=1, the 6th frame is dropped. After release, frames 1-5 execute in order.
REQ-025 Timeout (macro defined, TIMEOUT_CYCLES=16): a read with no rsp_valid -> tx_data=0xFF and tx_en after 16 cycles in WAIT_RSP.
REQ-026 Reset mid-read: rstn=0 during WAIT_RSP, then a late rsp_valid -> no tx_en, all outputs at reset values.
